downsize_arbiter: RTL and testbench

Round-robin scheduler that shares one `downsize` instance among N_REQ neuron accumulators. It grants at most one requester per cycle and registers that requester's wide parallel word onto the shared `downsize` input. It also tracks the datapath's fixed pipeline latency with a valid/ID delay line, so every narrowed output leaves tagged with the requester that produced it. It sits between the accumulator bank and the activation stage of the neuron layer.

---
 rtl/downsize_arbiter.sv | 115 +++++++++++
 tb/tb_downsize_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/downsize_arbiter.sv
// downsize_arbiter: round-robin share of one downsize datapath.
// Registers the granted word and tags results through a valid/id delay line.
module downsize_arbiter #(
    parameter int N_REQ       = 4,
    parameter int PARALLEL_IN = 4,
    parameter int DIN_WIDTH   = 32,
    parameter int DOUT_WIDTH  = 16,
    parameter int DS_LATENCY  = 1,
    parameter int ID_WIDTH    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     en,
    input  logic [N_REQ-1:0]                         req_valid,
    input  logic [N_REQ*PARALLEL_IN*DIN_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]                         req_ready,
    output logic [PARALLEL_IN*DIN_WIDTH-1:0]         ds_din,
    input  logic [PARALLEL_IN*DOUT_WIDTH-1:0]        ds_dout,
    output logic [PARALLEL_IN*DOUT_WIDTH-1:0]        dout,
    output logic                                     dout_valid,
    output logic [ID_WIDTH-1:0]                      dout_id
);

    localparam int WW = PARALLEL_IN * DIN_WIDTH;
    // Stage 0 is aligned with ds_din; DS_LATENCY more stages follow
    // so the tag lines up with ds_dout.
    localparam int NST = DS_LATENCY + 1;
    localparam logic [ID_WIDTH-1:0] LAST_RST = ID_WIDTH'(N_REQ - 1);

    logic [ID_WIDTH-1:0]           last_q, last_d;
    logic [WW-1:0]                 ds_din_q, ds_din_d;
    logic [NST-1:0]                vld_q, vld_d;
    logic [NST-1:0][ID_WIDTH-1:0]  id_q, id_d;

    logic                hi_found, lo_found, grant_found;
    logic [ID_WIDTH-1:0] hi_idx, lo_idx, grant_idx;
    logic                xfer;

    // Round-robin search: indices above last first, then wrap to the rest.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i]) begin
                if (i > int'(last_q)) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = ID_WIDTH'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = ID_WIDTH'(i);
                end
            end
        end
        grant_found = hi_found | lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    // One-hot grant, gated by enable and held off during reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = grant_found && en && rst_n &&
                           (grant_idx == ID_WIDTH'(i));
        end
    end

    assign xfer = |req_ready;

    // Next state: capture the granted slice and tag, shift the delay line.
    always_comb begin
        last_d   = last_q;
        ds_din_d = ds_din_q;
        vld_d    = '0;
        id_d     = id_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                ds_din_d = req_data[i*WW +: WW];
            end
        end
        if (xfer) begin
            last_d   = grant_idx;
            vld_d[0] = 1'b1;
            id_d[0]  = grant_idx;
        end
        for (int s = 1; s < NST; s++) begin
            vld_d[s] = vld_q[s-1];
            id_d[s]  = id_q[s-1];
        end
    end

    // State registers; async reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= LAST_RST;
            ds_din_q <= '0;
            vld_q    <= '0;
            id_q     <= '0;
        end else begin
            last_q   <= last_d;
            ds_din_q <= ds_din_d;
            vld_q    <= vld_d;
            id_q     <= id_d;
        end
    end

    assign ds_din     = ds_din_q;
    assign dout       = ds_dout;
    assign dout_valid = vld_q[NST-1];
    assign dout_id    = id_q[NST-1];

endmodule

// File: tb/tb_downsize_arbiter.sv
// tb_downsize_arbiter: directed bench with scoreboard for two latencies.
// A bench-side saturating downsize model feeds ds_dout.
module tb_downsize_arbiter;

    localparam int N   = 4;
    localparam int PI  = 4;
    localparam int DW  = 32;
    localparam int OW  = 16;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic [N-1:0]       req_valid;
    logic [N*PI*DW-1:0] req_data;

    logic [N-1:0]     rdy1, rdy3;
    logic [PI*DW-1:0] din1, din3;
    logic [PI*OW-1:0] dsout1, dsout3, dout1, dout3;
    logic             dv1, dv3;
    logic [IDW-1:0]   did1, did3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [IDW-1:0]   id;
        logic [PI*OW-1:0] d;
        int               due;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    downsize_arbiter #(.N_REQ(N), .PARALLEL_IN(PI), .DIN_WIDTH(DW),
                       .DOUT_WIDTH(OW), .DS_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(rdy1),
        .ds_din(din1), .ds_dout(dsout1), .dout(dout1),
        .dout_valid(dv1), .dout_id(did1)
    );

    downsize_arbiter #(.N_REQ(N), .PARALLEL_IN(PI), .DIN_WIDTH(DW),
                       .DOUT_WIDTH(OW), .DS_LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(rdy3),
        .ds_din(din3), .ds_dout(dsout3), .dout(dout3),
        .dout_valid(dv3), .dout_id(did3)
    );

    function automatic logic [OW-1:0] sat(logic [DW-1:0] w);
        if ($signed(w) > 32767) return 16'h7FFF;
        if ($signed(w) < -32768) return 16'h8000;
        return w[OW-1:0];
    endfunction

    function automatic logic [PI*OW-1:0] ds_f(logic [PI*DW-1:0] x);
        logic [PI*OW-1:0] r;
        r = '0;
        for (int j = 0; j < PI; j++) r[j*OW +: OW] = sat(x[j*DW +: DW]);
        return r;
    endfunction

    // Shared downsize models with latency 1 and 3.
    logic [PI*OW-1:0] m1 = '0;
    logic [PI*OW-1:0] m3 [3] = '{default: '0};
    always @(posedge clk) begin
        m1    <= ds_f(din1);
        m3[0] <= ds_f(din3);
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end
    assign dsout1 = m1;
    assign dsout3 = m3[2];

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitors: results must appear exactly on their due cycle.
    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("l1_valid", 128'(dv1), 128'(1'b1));
            chk("l1_id", 128'(did1), 128'(q1[0].id));
            chk("l1_dout", 128'(dout1), 128'(q1[0].d));
            void'(q1.pop_front());
        end else begin
            chk("l1_idle", 128'(dv1), 128'(1'b0));
        end
    end

    always @(negedge clk) begin
        if (q3.size() > 0 && q3[0].due == cyc) begin
            chk("l3_valid", 128'(dv3), 128'(1'b1));
            chk("l3_id", 128'(did3), 128'(q3[0].id));
            chk("l3_dout", 128'(dout3), 128'(q3[0].d));
            void'(q3.pop_front());
        end else begin
            chk("l3_idle", 128'(dv3), 128'(1'b0));
        end
    end

    task automatic fill(input bit fix);
        for (int i = 0; i < N * PI; i++) begin
            logic [31:0] w;
            if (fix) w = 32'h0001_2345;
            else begin
                case ($urandom_range(0, 2))
                    0:       w = 32'($urandom_range(0, 32767));
                    1:       w = -32'($urandom_range(1, 32768));
                    default: w = $urandom;
                endcase
            end
            req_data[i*DW +: DW] = w;
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic e,
                        input logic [N-1:0] exp_rdy, input string tag,
                        input bit fix = 1'b0);
        @(negedge clk);
        req_valid = v;
        en        = e;
        fill(fix);
        #1;
        chk({tag, "_rdy1"}, 128'(rdy1), 128'(exp_rdy));
        chk({tag, "_rdy3"}, 128'(rdy3), 128'(exp_rdy));
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i] && v[i] && e) begin
                exp_t x;
                x.id  = IDW'(i);
                x.d   = ds_f(req_data[i*PI*DW +: PI*DW]);
                x.due = cyc + 1 + 1;
                q1.push_back(x);
                x.due = cyc + 1 + 3;
                q3.push_back(x);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b1, '0, "idle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = '0;
        q1.delete();
        q3.delete();
        #1;
        chk("rst_dv1", 128'(dv1), 128'(1'b0));
        chk("rst_dv3", 128'(dv3), 128'(1'b0));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_data  = '0;
        #2;
        en        = 1'b1;
        req_valid = '1;
        #1;
        chk("rst_rdy1", 128'(rdy1), 128'(0));
        chk("rst_rdy3", 128'(rdy3), 128'(0));
        chk("rst_dv", 128'(dv1 | dv3), 128'(0));
        chk("rst_id", 128'({did1, did3}), 128'(0));
        chk("rst_din1", 128'(din1), 128'(0));
        chk("rst_din3", 128'(din3), 128'(0));
        req_valid = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Single requester 2 with fixed data.
        step(4'b0100, 1'b1, 4'b0100, "t1", 1'b1);
        @(posedge clk);
        #1;
        chk("t1_din1", din1, {4{32'h0001_2345}});
        chk("t1_din3", din3, {4{32'h0001_2345}});
        idle(5);

        // All four continuous: strict rotation from requester 0.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(4'b1111, 1'b1, 4'b0001 << (k % 4), "t2");
        end
        idle(4);

        // Enable low for three cycles after granting 1.
        step(4'b1010, 1'b1, 4'b0010, "t3a");
        step(4'b1010, 1'b0, 4'b0000, "t3off");
        step(4'b1010, 1'b0, 4'b0000, "t3off");
        step(4'b1010, 1'b0, 4'b0000, "t3off");
        step(4'b1010, 1'b1, 4'b1000, "t3b");
        step(4'b1010, 1'b1, 4'b0010, "t3c");
        idle(4);

        // Back-to-back grants, then async reset mid-cycle.
        step(4'b1111, 1'b1, 4'b0100, "t4");
        step(4'b1111, 1'b1, 4'b1000, "t4");
        step(4'b1111, 1'b1, 4'b0001, "t4");
        step(4'b1111, 1'b1, 4'b0010, "t4");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_dv1", 128'(dv1), 128'(1'b0));
        chk("t4_dv3", 128'(dv3), 128'(1'b0));
        chk("t4_rdy", 128'(rdy1 | rdy3), 128'(0));
        chk("t4_din", 128'(din1), 128'(0));
        req_valid = '0;
        q1.delete();
        q3.delete();
        #1;
        rst_n = 1'b1;
        idle(5);
        step(4'b1111, 1'b1, 4'b0001, "t4rel");
        idle(4);

        // Requester 0 on alternate cycles.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(4'b0001, 1'b1, 4'b0001, "t5on");
            step(4'b0000, 1'b1, 4'b0000, "t5off");
        end
        idle(5);

        chk("sb_empty1", 128'(q1.size()), 128'(0));
        chk("sb_empty3", 128'(q3.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
